// File: rtl/acc_pool_pkg.sv
// rtl/acc_pool_pkg.sv - shared state type and arithmetic helpers for acc_pool_stream
package acc_pool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Operands are carried at 32 bits so the helpers stay independent of the lane widths.
    function automatic logic signed [31:0] requant(
        input logic signed [31:0] sum,
        input logic        [4:0]  shift,
        input logic               relu,
        input int                 data_w
    );
        logic signed [31:0] sh;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sh = sum >>> shift;
        hi = (32'sd1 <<< (data_w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (relu && (sum < 32'sd0))
            requant = 32'sd0;
        else if (sh > hi)
            requant = hi;
        else if (sh < lo)
            requant = lo;
        else
            requant = sh;
    endfunction

    function automatic logic signed [31:0] smax(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        smax = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - one-row max-pool line buffer, async read-before-write
module pool_line_buffer #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is never reset: even rows always write a slot before odd rows read it.
    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[idx_i] <= wdata_i;
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/acc_pool_stream.sv
// rtl/acc_pool_stream.sv - per-lane accumulate, ReLU/requant and optional 2x2 max-pool stream
module acc_pool_stream
    import acc_pool_pkg::*;
#(
    parameter int LANES     = 16,
    parameter int PSUM_W    = 8,
    parameter int ACC_W     = 20,
    parameter int DATA_W    = 8,
    parameter int MAX_OFMAP = 32,
    parameter int ADDR_W    = 10,
    parameter int CH_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start_i,
    input  logic [5:0]              cfg_ofmap_size_i,
    input  logic [CH_W-1:0]         cfg_ch_i,
    input  logic [4:0]              cfg_shift_i,
    input  logic                    cfg_relu_en_i,
    input  logic                    cfg_pool_en_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [LANES*PSUM_W-1:0] in_psum_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0]       out_addr_o,
    output logic                    out_last_o
);

    localparam int LB_DEPTH = MAX_OFMAP / 2;
    localparam int IDX_W    = $clog2(LB_DEPTH);

    state_t state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [5:0]      col_q, col_d, row_q, row_d;
    logic [5:0]      s_q;
    logic [CH_W-1:0] c_q;
    logic [4:0]      shift_q;
    logic            relu_q, pool_q;
    logic            done_q, done_d;

    logic [LANES-1:0][ACC_W-1:0]  acc_q;
    logic [LANES-1:0][ACC_W-1:0]  sum_w;
    logic [LANES-1:0][DATA_W-1:0] hreg_q;
    logic [LANES-1:0][DATA_W-1:0] px_w;
    logic [LANES-1:0][DATA_W-1:0] pool_w;
    logic [LANES*DATA_W-1:0]      lb_wdata, lb_rdata;

    logic                    out_valid_q, out_valid_d;
    logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0]       out_addr_q, out_addr_d;
    logic                    out_last_q, out_last_d;

    logic       accept, last_ch, last_col, last_row, last_pixel;
    logic       emit, emit_last, lb_we, h_we;
    logic [5:0] s_m1, se_m1;
    logic [12:0] addr_full;

    assign in_ready_o = (state_q == RUN) && !(out_valid_q && !out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    assign s_m1       = s_q - 6'd1;
    assign se_m1      = {s_q[5:1], 1'b0} - 6'd1;
    assign last_ch    = (ch_q == c_q - CH_W'(1));
    assign last_col   = (col_q == s_m1);
    assign last_row   = (row_q == s_m1);
    assign last_pixel = last_ch && last_col && last_row;

    // Floor semantics fall out naturally: an odd trailing row/column never reaches an odd/odd slot.
    assign emit      = accept && last_ch && (!pool_q || (col_q[0] && row_q[0]));
    assign emit_last = pool_q ? ((row_q == se_m1) && (col_q == se_m1)) : (last_col && last_row);
    assign lb_we     = accept && last_ch && pool_q && col_q[0] && !row_q[0];
    assign h_we      = accept && last_ch && pool_q && !col_q[0];
    assign addr_full = pool_q ? (13'(row_q >> 1) * 13'(s_q >> 1) + 13'(col_q >> 1))
                              : (13'(row_q) * 13'(s_q) + 13'(col_q));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [PSUM_W-1:0] psum;
        logic signed [ACC_W-1:0]  sum;
        logic signed [31:0]       rq, hmax, pmax;
        assign psum = in_psum_i[l*PSUM_W +: PSUM_W];
        assign sum  = ((ch_q == '0) ? '0 : acc_q[l]) + ACC_W'(psum);
        assign rq   = requant(32'(sum), shift_q, relu_q, DATA_W);
        assign hmax = smax(32'($signed(hreg_q[l])), 32'($signed(px_w[l])));
        assign pmax = smax(32'($signed(lb_rdata[l*DATA_W +: DATA_W])), hmax);
        assign sum_w[l]                      = sum;
        assign px_w[l]                       = DATA_W'(rq);
        assign lb_wdata[l*DATA_W +: DATA_W]  = DATA_W'(hmax);
        assign pool_w[l]                     = DATA_W'(pmax);
    end

    pool_line_buffer #(
        .WIDTH (LANES*DATA_W),
        .DEPTH (LB_DEPTH),
        .IDX_W (IDX_W)
    ) u_line_buffer (
        .clk     (clk),
        .idx_i   (IDX_W'(col_q >> 1)),
        .we_i    (lb_we),
        .wdata_i (lb_wdata),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ch_d    = ch_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    ch_d  = '0;
                    col_d = '0;
                    row_d = '0;
                    if ((cfg_ofmap_size_i == '0) || (cfg_ch_i == '0))
                        done_d = 1'b1;
                    else
                        state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (!last_ch) begin
                        ch_d = ch_q + CH_W'(1);
                    end else begin
                        ch_d  = '0;
                        col_d = last_col ? 6'd0 : col_q + 6'd1;
                        if (last_col)
                            row_d = last_row ? 6'd0 : row_q + 6'd1;
                    end
                    // Without a final emit, any pending output is handshaking this same cycle.
                    if (last_pixel) begin
                        if (emit) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_valid_q && out_ready_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = pool_q ? pool_w : px_w;
            out_addr_d  = ADDR_W'(addr_full);
            out_last_d  = emit_last;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            ch_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            s_q         <= '0;
            c_q         <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            pool_q      <= 1'b0;
            acc_q       <= '0;
            hreg_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            ch_q        <= ch_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            if ((state_q == IDLE) && cfg_start_i) begin
                s_q     <= cfg_ofmap_size_i;
                c_q     <= cfg_ch_i;
                shift_q <= cfg_shift_i;
                relu_q  <= cfg_relu_en_i;
                pool_q  <= cfg_pool_en_i;
            end
            if (accept)
                acc_q <= sum_w;
            if (h_we)
                hreg_q <= px_w;
        end
    end

    assign busy_o      = (state_q != IDLE) || done_q;
    assign done_o      = done_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_addr_o  = out_addr_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_acc_pool_stream.sv
// tb/tb_acc_pool_stream.sv - scoreboard bench for acc_pool_stream
module tb_acc_pool_stream;

    localparam int LANES  = 16;
    localparam int PSUM_W = 8;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int CH_W   = 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    cfg_start_i;
    logic [5:0]              cfg_ofmap_size_i;
    logic [CH_W-1:0]         cfg_ch_i;
    logic [4:0]              cfg_shift_i;
    logic                    cfg_relu_en_i;
    logic                    cfg_pool_en_i;
    logic                    busy_o, done_o;
    logic                    in_valid_i, in_ready_o;
    logic [LANES*PSUM_W-1:0] in_psum_i;
    logic                    out_valid_o, out_ready_i;
    logic [LANES*DATA_W-1:0] out_data_o;
    logic [ADDR_W-1:0]       out_addr_o;
    logic                    out_last_o;

    typedef struct {
        logic [7:0] d;
        logic [9:0] a;
        logic       l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_hs_cyc = -10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    acc_pool_stream dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_start_i      (cfg_start_i),
        .cfg_ofmap_size_i (cfg_ofmap_size_i),
        .cfg_ch_i         (cfg_ch_i),
        .cfg_shift_i      (cfg_shift_i),
        .cfg_relu_en_i    (cfg_relu_en_i),
        .cfg_pool_en_i    (cfg_pool_en_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_psum_i        (in_psum_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_data_o       (out_data_o),
        .out_addr_o       (out_addr_o),
        .out_last_o       (out_last_o)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] d, input logic [9:0] a, input logic l);
        exp_t e;
        e.d = d;
        e.a = a;
        e.l = l;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got addr %0d data %0h expected none", out_addr_o, out_data_o);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", out_data_o, {LANES{mon_e.d}});
                check("out_addr", out_addr_o, mon_e.a);
                check("out_last", out_last_o, mon_e.l);
                if (mon_e.l)
                    last_hs_cyc = cyc;
            end
        end
    end

    task automatic check_reset_outputs(input string nm);
        check({nm, "_busy"}, busy_o, 0);
        check({nm, "_done"}, done_o, 0);
        check({nm, "_in_ready"}, in_ready_o, 0);
        check({nm, "_out_valid"}, out_valid_o, 0);
        check({nm, "_out_last"}, out_last_o, 0);
        check({nm, "_out_data"}, out_data_o, 0);
        check({nm, "_out_addr"}, out_addr_o, 0);
    endtask

    task automatic start_job(input int s, input int c, input int sh, input bit relu, input bit pool);
        @(posedge clk) #1;
        cfg_ofmap_size_i = 6'(s);
        cfg_ch_i         = CH_W'(c);
        cfg_shift_i      = 5'(sh);
        cfg_relu_en_i    = relu;
        cfg_pool_en_i    = pool;
        cfg_start_i      = 1'b1;
        @(posedge clk) #1;
        cfg_start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic beat(input int v);
        logic [7:0] b;
        bit ok;
        b = 8'(v);
        in_psum_i  = {LANES{b}};
        in_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready_o;
            @(posedge clk) #1;
        end
        in_valid_i = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_timeout: got no in_ready expected beat %0d accepted", v);
        end
    endtask

    task automatic wait_done(input bit chk_hs);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = done_o;
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("busy_at_done", busy_o, 1);
            if (chk_hs)
                check("done_after_hs", cyc, last_hs_cyc + 1);
            @(negedge clk);
            check("done_one_cycle", done_o, 0);
            check("busy_after_done", busy_o, 0);
        end
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b0;
        cfg_start_i      = 1'b0;
        cfg_ofmap_size_i = '0;
        cfg_ch_i         = '0;
        cfg_shift_i      = '0;
        cfg_relu_en_i    = 1'b0;
        cfg_pool_en_i    = 1'b0;
        in_valid_i       = 1'b0;
        in_psum_i        = '0;
        out_ready_i      = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // plain accumulate: 1+2+3 per pixel
        start_job(2, 3, 0, 0, 0);
        for (int p = 0; p < 4; p++) expect_out(8'd6, 10'(p), p == 3);
        for (int p = 0; p < 4; p++) begin
            beat(1); beat(2); beat(3);
        end
        wait_done(1);

        // ReLU clamps negative
        start_job(1, 1, 0, 1, 0);
        expect_out(8'd0, 0, 1);
        beat(-100);
        wait_done(1);

        // positive saturation 254 -> 127
        start_job(1, 2, 0, 0, 0);
        expect_out(8'd127, 0, 1);
        beat(127); beat(127);
        wait_done(1);

        // negative saturation -256 -> -128
        start_job(1, 2, 0, 0, 0);
        expect_out(8'h80, 0, 1);
        beat(-128); beat(-128);
        wait_done(1);

        // shift 400 >>> 2 = 100, >>> 3 = 50
        start_job(1, 4, 2, 0, 0);
        expect_out(8'd100, 0, 1);
        repeat (4) beat(100);
        wait_done(1);
        start_job(1, 4, 3, 0, 0);
        expect_out(8'd50, 0, 1);
        repeat (4) beat(100);
        wait_done(1);

        // 2x2 pool on S=4
        start_job(4, 1, 0, 0, 1);
        expect_out(8'd5, 0, 0);
        expect_out(8'd7, 1, 0);
        expect_out(8'd13, 2, 0);
        expect_out(8'd15, 3, 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) beat(r * 4 + c);
        wait_done(1);

        // S=5: odd last row/column dropped, done follows last beat
        start_job(5, 1, 0, 0, 1);
        expect_out(8'd5, 0, 0);
        expect_out(8'd7, 1, 0);
        expect_out(8'd13, 2, 0);
        expect_out(8'd15, 3, 1);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) beat(r * 4 + c);
        wait_done(0);

        // pool with S=1 emits nothing
        start_job(1, 1, 0, 0, 1);
        beat(9);
        wait_done(0);

        // degenerate sizes finish without output
        start_job(0, 3, 0, 0, 0);
        wait_done(0);
        start_job(2, 0, 0, 0, 0);
        wait_done(0);

        // backpressure on the first output
        out_ready_i = 1'b0;
        start_job(2, 1, 0, 0, 0);
        expect_out(8'd10, 0, 0);
        expect_out(8'd20, 1, 0);
        expect_out(8'd30, 2, 0);
        expect_out(8'd40, 3, 1);
        fork
            begin
                beat(10); beat(20); beat(30); beat(40);
            end
            begin
                bit got;
                got = 1'b0;
                for (int i = 0; i < 50 && !got; i++) begin
                    @(negedge clk);
                    got = out_valid_o;
                end
                check("stall_out_valid_seen", got, 1);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("stall_in_ready", in_ready_o, 0);
                    check("stall_out_valid", out_valid_o, 1);
                    check("stall_out_data", out_data_o, {LANES{8'd10}});
                end
                @(posedge clk) #1;
                out_ready_i = 1'b1;
            end
        join
        wait_done(1);

        // reset mid-job, then a clean pooled job
        start_job(4, 2, 0, 0, 1);
        repeat (11) beat(50);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        @(posedge clk) #1;
        rst_n = 1'b1;
        start_job(4, 2, 0, 0, 1);
        expect_out(8'd6, 0, 0);
        expect_out(8'd8, 1, 0);
        expect_out(8'd14, 2, 0);
        expect_out(8'd16, 3, 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                beat(r * 4 + c);
                beat(1);
            end
        wait_done(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
